dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single-port, 1-cycle-read-latency data memory between the CPU MEM stage and the UART loader/monitor. CPU has fixed priority, and a saturating starvation counter guarantees the UART a slot. The block drives the memory port and the CPU pipeline stall; it sits between the MEM stage (ahead of the MEM/WB register) and the data RAM.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 16, data word width
MAX_WAIT, 4, UART waiting cycles after which UART beats a pending CPU request (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  MEM stage access request, held until cpu_done
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_done  out  1  access complete this cycle
cpu_stall  out  1  cpu_req & ~cpu_done; freezes PC/IF/ID/EX/MEM registers
cpu_rdata  out  DATA_W  CPU read data
uart_req  in  1  UART access request, held until uart_ack
uart_we  in  1  1=write, 0=read
uart_addr  in  ADDR_W  UART address
uart_wdata  in  DATA_W  UART write data
uart_ack  out  1  UART access complete this cycle
uart_rdata  out  DATA_W  UART read data
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read issue

Behaviour:
- State register: IDLE, RD_CPU, RD_UART. Async reset -> IDLE, wait_cnt=0, cpu_rd_hold=0, uart_rd_hold=0.
- While reset low, all outputs are 0, including combinational ones. Reset mid-read abandons the read: no done/ack is issued, and the requester reissues after reset.
- Arbitration, IDLE only:
  - starve = (wait_cnt >= MAX_WAIT).
  - Winner: UART if uart_req & starve; else CPU if cpu_req; else UART if uart_req; else none.
- Issue cycle, IDLE with a winner:
  - mem_en=1; mem_we, mem_addr, mem_wdata taken combinationally from the winner.
  - Write: winner's cpu_done or uart_ack = 1 in the same cycle; stay IDLE. A write takes 1 cycle.
  - Read: next state RD_CPU or RD_UART.
- Memory outputs: mem_en=mem_we=0 and mem_addr/mem_wdata=0 in IDLE with no winner and in both RD states.
- RD_CPU: cpu_done=1; cpu_rdata=mem_rdata combinationally; cpu_rd_hold<=mem_rdata at the clock edge; next IDLE. RD_UART is the same with uart_ack/uart_rdata/uart_rd_hold. A read takes 2 cycles and always leaves one bubble: no new issue in an RD state.
- Outside its RD state, each rdata output drives its hold register (last read value, 0 after reset).
- cpu_stall = cpu_req & ~cpu_done at all times, including while UART owns the port or during RD_UART.
- wait_cnt (4 bits, saturating at MAX_WAIT):
  - cleared when uart_ack=1 or uart_req=0;
  - otherwise incremented each cycle uart_req=1 & uart_ack=0.
- Simultaneous requests with wait_cnt<MAX_WAIT: CPU wins and UART keeps waiting.
- Continuous CPU traffic: UART is served no later than the first IDLE cycle after wait_cnt reaches MAX_WAIT.
- Requester dropping req before done/ack is illegal; behaviour is undefined, and the bench asserts against it.
- Requester changing we/addr/wdata while waiting: the values present in the issue cycle are used.
- Done/ack is a single-cycle pulse per access. A requester that keeps req high after done/ack is treated as making a new request in the next IDLE cycle.

Test Plan:
- Reset: hold reset=0 with cpu_req=1, uart_req=1 -> all outputs 0. Release -> first cycle issues CPU.
- CPU write then read: cpu write addr 0x12 data 0xBEEF, then read 0x12. Expected: write has mem_en=mem_we=1 and cpu_done in the same cycle with cpu_stall=0; read has stall=1 in the issue cycle and cpu_done=1, cpu_rdata=0xBEEF the next cycle; cpu_rdata still 0xBEEF afterwards.
- Collision: cpu_req (read 0x01) and uart_req (write 0x02, 0x1234) rise together -> CPU issues first. UART write issues in the cycle after cpu_done, and uart_ack comes in that cycle.
- Starvation: CPU back-to-back writes every cycle plus a continuous uart read of 0x40 (RAM holds 0x5A5A), MAX_WAIT=4 -> UART issued on the 5th cycle of waiting. uart_ack=1 with uart_rdata=0x5A5A one cycle later; cpu_stall=1 in both cycles; wait_cnt back to 0.
- Reset mid-read: assert reset during RD_UART -> uart_ack never pulses and uart_rdata=0. After release, a held uart_req reissues and completes normally.
- Back-to-back reads: CPU reads 0x00..0x03 -> exactly 8 cycles, alternating issue and data, with mem_en=0 in every data cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the 1-cycle-latency data RAM between the
// MEM stage (fixed priority) and the UART loader, with a starvation guard.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  output logic              uart_ack,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CPU  = 2'd1,
    RD_UART = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_wait_cnt;
  logic [DATA_W-1:0] r_cpu_rd_hold;
  logic [DATA_W-1:0] r_uart_rd_hold;
  logic              w_idle;
  logic              w_starve;
  logic              w_gnt_cpu;
  logic              w_gnt_uart;

  assign w_idle     = (r_state == IDLE);
  assign w_starve   = (r_wait_cnt >= LP_MAX);
  assign w_gnt_uart = w_idle & uart_req & (w_starve | ~cpu_req);
  assign w_gnt_cpu  = w_idle & cpu_req & ~(uart_req & w_starve);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_cpu & ~cpu_we)        w_next = RD_CPU;
        else if (w_gnt_uart & ~uart_we) w_next = RD_UART;
      end
      RD_CPU:  w_next = IDLE;
      RD_UART: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_done   = 1'b0;
    uart_ack   = 1'b0;
    cpu_rdata  = '0;
    uart_rdata = '0;
    if (reset) begin
      cpu_rdata  = r_cpu_rd_hold;
      uart_rdata = r_uart_rd_hold;
      unique case (1'b1)
        w_gnt_cpu: begin
          mem_en    = 1'b1;
          mem_we    = cpu_we;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          cpu_done  = cpu_we;
        end
        w_gnt_uart: begin
          mem_en    = 1'b1;
          mem_we    = uart_we;
          mem_addr  = uart_addr;
          mem_wdata = uart_wdata;
          uart_ack  = uart_we;
        end
        default: ;
      endcase
      if (r_state == RD_CPU) begin
        cpu_done  = 1'b1;
        cpu_rdata = mem_rdata;
      end
      if (r_state == RD_UART) begin
        uart_ack   = 1'b1;
        uart_rdata = mem_rdata;
      end
    end
  end

  assign cpu_stall = reset & cpu_req & ~cpu_done;

  // Wait counter saturates so the UART keeps its claim until served
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt     <= '0;
      r_cpu_rd_hold  <= '0;
      r_uart_rd_hold <= '0;
    end else begin
      if (r_state == RD_CPU)  r_cpu_rd_hold  <= mem_rdata;
      if (r_state == RD_UART) r_uart_rd_hold <= mem_rdata;
      if (!uart_req || uart_ack)  r_wait_cnt <= '0;
      else if (r_wait_cnt < LP_MAX) r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed + random stimulus against a
// transaction-level reference model of the port arbiter.
module tb_dmem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_done;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          uart_req = 1'b0;
  logic          uart_we = 1'b0;
  logic [AW-1:0] uart_addr = '0;
  logic [DW-1:0] uart_wdata = '0;
  logic          uart_ack;
  logic [DW-1:0] uart_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  dmem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata),
    .uart_req(uart_req), .uart_we(uart_we),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_ack(uart_ack), .uart_rdata(uart_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 8'h40) ? 16'h5A5A : 16'h0000;
  endfunction

  // Synchronous RAM, 1-cycle read latency
  bit   [DW-1:0] ram    [256];
  bit            ram_wr [256];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        ram_q <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
      end
    end
  end
  assign mem_rdata = ram_q;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner of a pending read, consecutive UART
  // waiting cycles (unbounded), shadow memory, last read values.
  bit   [DW-1:0] sh    [256];
  bit            sh_wr [256];
  int            m_owner = 0;
  logic [AW-1:0] m_raddr = '0;
  int            m_wait = 0;
  logic [DW-1:0] m_cpu_last = '0;
  logic [DW-1:0] m_uart_last = '0;
  int            n_owner = 0;
  logic [AW-1:0] n_raddr = '0;
  int            n_wait = 0;
  logic [DW-1:0] n_cpu_last = '0;
  logic [DW-1:0] n_uart_last = '0;
  bit            n_wr = 1'b0;
  logic [AW-1:0] n_waddr = '0;
  logic [DW-1:0] n_wdata = '0;
  bit            p_cpu_pend = 1'b0;
  bit            p_uart_pend = 1'b0;

  function automatic logic [DW-1:0] shread(input logic [AW-1:0] a);
    return sh_wr[a] ? sh[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    logic          e_en, e_we, e_done, e_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_crd, e_urd;
    int            win;
    e_en = 0; e_we = 0; e_done = 0; e_ack = 0;
    e_addr = '0; e_wd = '0; e_crd = '0; e_urd = '0;
    win = 0;
    n_wr <= 1'b0;
    n_owner <= 0;
    n_raddr <= m_raddr;
    n_wait <= 0;
    n_cpu_last <= '0;
    n_uart_last <= '0;
    if (reset) begin
      e_crd = m_cpu_last;
      e_urd = m_uart_last;
      if (m_owner == 1) begin
        e_done = 1;
        e_crd = shread(m_raddr);
      end else if (m_owner == 2) begin
        e_ack = 1;
        e_urd = shread(m_raddr);
      end else begin
        if (uart_req && m_wait >= MW) win = 2;
        else if (cpu_req)             win = 1;
        else if (uart_req)            win = 2;
        if (win == 1) begin
          e_en = 1; e_we = cpu_we; e_addr = cpu_addr;
          e_wd = cpu_wdata; e_done = cpu_we;
        end
        if (win == 2) begin
          e_en = 1; e_we = uart_we; e_addr = uart_addr;
          e_wd = uart_wdata; e_ack = uart_we;
        end
        if (win != 0 && e_we) begin
          n_wr <= 1'b1;
          n_waddr <= e_addr;
          n_wdata <= e_wd;
        end
        if (win != 0 && !e_we) begin
          n_owner <= win;
          n_raddr <= e_addr;
        end
      end
      n_wait <= (uart_req && !e_ack) ? m_wait + 1 : 0;
      n_cpu_last <= e_crd;
      n_uart_last <= e_urd;
      if (p_cpu_pend)  chk("cpu_req_held", cpu_req, 1'b1);
      if (p_uart_pend) chk("uart_req_held", uart_req, 1'b1);
    end
    chk("m_mem_en", mem_en, e_en);
    chk("m_mem_we", mem_we, e_we);
    chk("m_mem_addr", mem_addr, e_addr);
    chk("m_mem_wdata", mem_wdata, e_wd);
    chk("m_cpu_done", cpu_done, e_done);
    chk("m_cpu_stall", cpu_stall, reset & cpu_req & ~e_done);
    chk("m_cpu_rdata", cpu_rdata, e_crd);
    chk("m_uart_ack", uart_ack, e_ack);
    chk("m_uart_rdata", uart_rdata, e_urd);
    p_cpu_pend  <= reset & cpu_req & ~e_done;
    p_uart_pend <= reset & uart_req & ~e_ack;
  end

  always @(posedge clk) begin
    if (n_wr) begin
      sh[n_waddr]    <= n_wdata;
      sh_wr[n_waddr] <= 1'b1;
    end
    m_owner     <= n_owner;
    m_raddr     <= n_raddr;
    m_wait      <= n_wait;
    m_cpu_last  <= n_cpu_last;
    m_uart_last <= n_uart_last;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic cpu_set(input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic uart_set(input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    uart_req = r; uart_we = w; uart_addr = a; uart_wdata = d;
  endtask

  initial begin
    bit cd, ud;
    int cwait, uwait, c0, c1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    cpu_set(1, 1, 8'h12, 16'hBEEF);
    uart_set(1, 0, 8'h40, 16'h0);
    // reset holds every output low
    repeat (2) tick;
    at_neg;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_ack", uart_ack, 0);
    chk("rst_addr", mem_addr, 0);
    tick;
    reset = 1'b1;
    at_neg;
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_addr", mem_addr, 8'h12);
    chk("wr_wdata", mem_wdata, 16'hBEEF);
    chk("wr_done", cpu_done, 1);
    chk("wr_stall", cpu_stall, 0);
    tick;
    cpu_set(1, 0, 8'h12, 16'h0);
    at_neg;
    chk("rd_iss_en", mem_en, 1);
    chk("rd_iss_we", mem_we, 0);
    chk("rd_iss_stall", cpu_stall, 1);
    chk("rd_iss_done", cpu_done, 0);
    tick;
    at_neg;
    chk("rd_dat_done", cpu_done, 1);
    chk("rd_dat_rdata", cpu_rdata, 16'hBEEF);
    chk("rd_dat_en", mem_en, 0);
    tick;
    cpu_set(0, 0, 8'h0, 16'h0);
    at_neg;
    chk("u_iss_addr", mem_addr, 8'h40);
    chk("rd_hold", cpu_rdata, 16'hBEEF);
    tick;
    at_neg;
    chk("u_ack", uart_ack, 1);
    chk("u_rdata", uart_rdata, 16'h5A5A);
    tick;
    uart_set(0, 0, 8'h0, 16'h0);
    tick;
    // collision
    cpu_set(1, 0, 8'h01, 16'h0);
    uart_set(1, 1, 8'h02, 16'h1234);
    at_neg;
    chk("col_addr", mem_addr, 8'h01);
    chk("col_ack0", uart_ack, 0);
    chk("col_stall", cpu_stall, 1);
    tick;
    at_neg;
    chk("col_done", cpu_done, 1);
    chk("col_ack1", uart_ack, 0);
    tick;
    cpu_set(0, 0, 8'h0, 16'h0);
    at_neg;
    chk("col_u_we", mem_we, 1);
    chk("col_u_addr", mem_addr, 8'h02);
    chk("col_u_wd", mem_wdata, 16'h1234);
    chk("col_u_ack", uart_ack, 1);
    tick;
    // starvation
    uart_set(1, 0, 8'h40, 16'h0);
    for (int k = 0; k < 4; k++) begin
      cpu_set(1, 1, 8'(8'h20 + k), 16'(k));
      at_neg;
      chk("stv_cpu_done", cpu_done, 1);
      chk("stv_ack0", uart_ack, 0);
      tick;
    end
    at_neg;
    chk("stv_u_addr", mem_addr, 8'h40);
    chk("stv_u_en", mem_en, 1);
    chk("stv_stall1", cpu_stall, 1);
    tick;
    at_neg;
    chk("stv_ack", uart_ack, 1);
    chk("stv_rdata", uart_rdata, 16'h5A5A);
    chk("stv_stall2", cpu_stall, 1);
    tick;
    uart_set(0, 0, 8'h0, 16'h0);
    at_neg;
    chk("stv_cpu_back", cpu_done, 1);
    tick;
    cpu_set(0, 0, 8'h0, 16'h0);
    tick;
    // reset during RD_UART
    uart_set(1, 0, 8'h40, 16'h0);
    at_neg;
    chk("mr_iss", mem_addr, 8'h40);
    tick;
    reset = 1'b0;
    at_neg;
    chk("mr_ack", uart_ack, 0);
    chk("mr_rdata", uart_rdata, 0);
    tick;
    reset = 1'b1;
    at_neg;
    chk("mr_reiss", mem_addr, 8'h40);
    tick;
    at_neg;
    chk("mr_ack2", uart_ack, 1);
    chk("mr_rdata2", uart_rdata, 16'h5A5A);
    tick;
    uart_set(0, 0, 8'h0, 16'h0);
    tick;
    // back-to-back CPU reads
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      cpu_set(1, 0, 8'(i), 16'h0);
      at_neg;
      chk("b2b_iss_en", mem_en, 1);
      chk("b2b_iss_addr", mem_addr, 32'(i));
      tick;
      at_neg;
      chk("b2b_dat_en", mem_en, 0);
      chk("b2b_dat_done", cpu_done, 1);
      if (i == 2) chk("b2b_rdata2", cpu_rdata, 16'h1234);
      c1 = cyc;
      tick;
    end
    cpu_set(0, 0, 8'h0, 16'h0);
    chk("b2b_cycles", c1 - c0 + 1, 8);
    // random traffic
    cwait = 0;
    uwait = 0;
    repeat (3000) begin
      at_neg;
      cd = cpu_done;
      ud = uart_ack;
      tick;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
      if (cpu_req && !cd) begin
        cwait++;
        if (cwait > 20) begin
          chk("cpu_wait_bound", cwait, 20);
          cwait = 0;
        end
        if ($urandom_range(0, 7) == 0)
          cpu_set(1, 1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom));
      end else begin
        cwait = 0;
        cpu_set($urandom_range(0, 99) < 60, 1'($urandom),
                8'($urandom_range(0, 15)), 16'($urandom));
      end
      if (uart_req && !ud) begin
        uwait++;
        if (uwait > 20) begin
          chk("uart_wait_bound", uwait, 20);
          uwait = 0;
        end
        if ($urandom_range(0, 7) == 0)
          uart_set(1, 1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom));
      end else begin
        uwait = 0;
        uart_set($urandom_range(0, 99) < 30, 1'($urandom),
                 8'($urandom_range(0, 15)), 16'($urandom));
      end
    end
    at_neg;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
